// File: rtl/pc_seq_pkg.sv
`default_nettype none
// ============================================================================
// pc_seq_pkg : op codes, condition codes and FSM state encodings
// Rev 1.0
// ============================================================================
package pc_seq_pkg;

  localparam logic [2:0] OP_INC    = 3'b000;
  localparam logic [2:0] OP_JUMP   = 3'b001;
  localparam logic [2:0] OP_BRANCH = 3'b010;
  localparam logic [2:0] OP_CALL   = 3'b011;
  localparam logic [2:0] OP_RET    = 3'b100;
  localparam logic [2:0] OP_HALT   = 3'b101;

  localparam logic [3:0] CC_ALWAYS = 4'd0;
  localparam logic [3:0] CC_EQ     = 4'd1;
  localparam logic [3:0] CC_NE     = 4'd2;
  localparam logic [3:0] CC_LT     = 4'd3;
  localparam logic [3:0] CC_GE     = 4'd4;
  localparam logic [3:0] CC_GT     = 4'd5;
  localparam logic [3:0] CC_LE     = 4'd6;
  localparam logic [3:0] CC_CS     = 4'd7;
  localparam logic [3:0] CC_CC     = 4'd8;
  localparam logic [3:0] CC_MI     = 4'd9;
  localparam logic [3:0] CC_PL     = 4'd10;
  localparam logic [3:0] CC_VS     = 4'd11;
  localparam logic [3:0] CC_VC     = 4'd12;
  localparam logic [3:0] CC_GTZ    = 4'd13;
  localparam logic [3:0] CC_NEVER  = 4'd14;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

endpackage
`default_nettype wire

// File: rtl/pc_sequencer_if.sv
`default_nettype none
// ============================================================================
// pc_sequencer_if : decoder <-> sequencer bus (master = decoder side)
// Rev 1.0
// ============================================================================
interface pc_sequencer_if #(
  parameter int PC_WIDTH  = 16,
  parameter int OFF_WIDTH = 8,
  parameter int RAS_DEPTH = 8
);
  localparam int CNT_WIDTH = $clog2(RAS_DEPTH) + 1;

  logic                 stall;
  logic [2:0]           op;
  logic [3:0]           cond;
  logic                 V;
  logic                 C;
  logic                 N;
  logic                 Z;
  logic [OFF_WIDTH-1:0] branch_offset;
  logic [PC_WIDTH-1:0]  jump_addr;
  logic [PC_WIDTH-1:0]  PC;
  logic [CNT_WIDTH-1:0] ras_count;
  logic                 ras_overflow;
  logic                 ras_underflow;
  logic                 halted;

  modport master (
    output stall, op, cond, V, C, N, Z, branch_offset, jump_addr,
    input  PC, ras_count, ras_overflow, ras_underflow, halted
  );

  modport slave (
    input  stall, op, cond, V, C, N, Z, branch_offset, jump_addr,
    output PC, ras_count, ras_overflow, ras_underflow, halted
  );
endinterface
`default_nettype wire

// File: rtl/pc_sequencer_return_stack.sv
`default_nettype none
// ============================================================================
// return_stack : circular LIFO; a push when full overwrites the oldest entry
// Rev 1.0
// ============================================================================
module return_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           push_data,
  output logic [WIDTH-1:0]           top_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] w_top_idx;

  // r_ptr is the next free slot; wrapping it naturally recycles the oldest entry
  assign w_top_idx = r_ptr - PTR_W'(1);
  assign top_data  = r_mem[w_top_idx];
  assign count     = r_count;
  assign full      = (r_count == CNT_W'(DEPTH));
  assign empty     = (r_count == '0);

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_ptr   <= '0;
      r_count <= '0;
    end else if (push) begin
      r_mem[r_ptr] <= push_data;
      r_ptr        <= r_ptr + PTR_W'(1);
      if (!full) r_count <= r_count + CNT_W'(1);
    end else if (pop && !empty) begin
      r_ptr   <= w_top_idx;
      r_count <= r_count - CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// pc_sequencer : program-counter sequencer with branch conditions and RAS
// Rev 1.0
// ============================================================================
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int                 PC_WIDTH     = 16,
  parameter int                 OFF_WIDTH    = 8,
  parameter int                 RAS_DEPTH    = 8,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic           clock,
  input  logic           reset,
  pc_sequencer_if.slave  bus
);
  localparam int CNT_WIDTH = $clog2(RAS_DEPTH) + 1;

  logic [PC_WIDTH-1:0]  r_pc;
  logic [0:0]           r_state;
  logic                 r_ovf;
  logic                 r_unf;

  logic [PC_WIDTH-1:0]  w_pc_inc;
  logic [PC_WIDTH-1:0]  w_off_sext;
  logic [PC_WIDTH-1:0]  w_br_target;
  logic [PC_WIDTH-1:0]  w_pc_next;
  logic [PC_WIDTH-1:0]  w_ras_top;
  logic [CNT_WIDTH-1:0] w_ras_count;
  logic                 w_ras_full;
  logic                 w_ras_empty;
  logic                 w_nv;
  logic                 w_cond_true;
  logic                 w_active;
  logic                 w_push;
  logic                 w_pop;

  assign w_pc_inc    = r_pc + PC_WIDTH'(1);
  assign w_off_sext  = PC_WIDTH'($signed(bus.branch_offset));
  assign w_br_target = r_pc + w_off_sext;
  assign w_nv        = bus.N ^ bus.V;

  always_comb begin
    w_cond_true = 1'b0;
    case (bus.cond)
      CC_ALWAYS: w_cond_true = 1'b1;
      CC_EQ:     w_cond_true = bus.Z;
      CC_NE:     w_cond_true = ~bus.Z;
      CC_LT:     w_cond_true = w_nv;
      CC_GE:     w_cond_true = ~w_nv;
      CC_GT:     w_cond_true = ~bus.Z & ~w_nv;
      CC_LE:     w_cond_true = bus.Z | w_nv;
      CC_CS:     w_cond_true = bus.C;
      CC_CC:     w_cond_true = ~bus.C;
      CC_MI:     w_cond_true = bus.N;
      CC_PL:     w_cond_true = ~bus.N;
      CC_VS:     w_cond_true = bus.V;
      CC_VC:     w_cond_true = ~bus.V;
      CC_GTZ:    w_cond_true = ~bus.N & ~bus.Z;
      default:   w_cond_true = 1'b0;
    endcase
  end

  always_comb begin
    w_pc_next = w_pc_inc;
    case (bus.op)
      OP_JUMP:   w_pc_next = bus.jump_addr;
      OP_BRANCH: w_pc_next = w_cond_true ? w_br_target : w_pc_inc;
      OP_CALL:   w_pc_next = bus.jump_addr;
      OP_RET:    w_pc_next = w_ras_empty ? w_pc_inc : w_ras_top;
      OP_HALT:   w_pc_next = r_pc;
      default:   w_pc_next = w_pc_inc;
    endcase
  end

  assign w_active = (r_state == ST_RUN) && !bus.stall;
  assign w_push   = w_active && (bus.op == OP_CALL);
  assign w_pop    = w_active && (bus.op == OP_RET) && !w_ras_empty;

  return_stack #(
    .WIDTH (PC_WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clock     (clock),
    .reset     (reset),
    .push      (w_push),
    .pop       (w_pop),
    .push_data (w_pc_inc),
    .top_data  (w_ras_top),
    .count     (w_ras_count),
    .full      (w_ras_full),
    .empty     (w_ras_empty)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_pc    <= RESET_VECTOR;
      r_state <= ST_RUN;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else if (w_active) begin
      r_pc <= w_pc_next;
      if (bus.op == OP_HALT)               r_state <= ST_HALT;
      if (w_push && w_ras_full)            r_ovf   <= 1'b1;
      if (bus.op == OP_RET && w_ras_empty) r_unf   <= 1'b1;
    end
  end

  assign bus.PC            = r_pc;
  assign bus.ras_count     = w_ras_count;
  assign bus.ras_overflow  = r_ovf;
  assign bus.ras_underflow = r_unf;
  assign bus.halted        = (r_state == ST_HALT);

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// tb_pc_sequencer : directed vectors, expected results queued to a monitor
// Rev 1.0
// ============================================================================
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  typedef struct packed {
    logic [15:0] pc;
    logic [3:0]  cnt;
    logic        ovf;
    logic        unf;
    logic        halt;
  } exp_t;

  logic  clock = 1'b0;
  logic  reset = 1'b0;
  exp_t  exp_q [$];
  string name_q [$];
  int    n_vec  = 0;
  int    n_miss = 0;

  always #5 clock = ~clock;

  pc_sequencer_if #(.PC_WIDTH(16), .OFF_WIDTH(8), .RAS_DEPTH(8)) bus ();

  pc_sequencer #(
    .PC_WIDTH     (16),
    .OFF_WIDTH    (8),
    .RAS_DEPTH    (8),
    .RESET_VECTOR (16'h0000)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic step(input string nm, input logic rst_n, input logic stl,
                      input logic [2:0] o, input logic [3:0] cc, input logic [3:0] vcnz,
                      input logic [7:0] off, input logic [15:0] ja,
                      input logic [15:0] e_pc, input logic [3:0] e_cnt,
                      input logic e_ovf, input logic e_unf, input logic e_halt);
    exp_t e;
    @(negedge clock);
    reset             = rst_n;
    bus.stall         = stl;
    bus.op            = o;
    bus.cond          = cc;
    {bus.V, bus.C, bus.N, bus.Z} = vcnz;
    bus.branch_offset = off;
    bus.jump_addr     = ja;
    e = '{pc: e_pc, cnt: e_cnt, ovf: e_ovf, unf: e_unf, halt: e_halt};
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: outputs are registered, so each vector's result is sampled just after the edge
  always @(posedge clock) begin
    exp_t  e;
    exp_t  got;
    string nm;
    #1;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      nm  = name_q.pop_front();
      got = '{pc: bus.PC, cnt: bus.ras_count, ovf: bus.ras_overflow,
              unf: bus.ras_underflow, halt: bus.halted};
      n_vec++;
      if (got !== e) begin
        n_miss++;
        $display("FAIL %s: got pc=%h cnt=%0d ovf=%b unf=%b halt=%b, want pc=%h cnt=%0d ovf=%b unf=%b halt=%b",
                 nm, got.pc, got.cnt, got.ovf, got.unf, got.halt,
                 e.pc, e.cnt, e.ovf, e.unf, e.halt);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.stall = 1'b0; bus.op = OP_INC; bus.cond = CC_ALWAYS;
    {bus.V, bus.C, bus.N, bus.Z} = 4'b0000;
    bus.branch_offset = '0; bus.jump_addr = '0;

    // reset and increment
    step("reset0",  0, 0, OP_INC,  0, 0, 0, 0,        16'h0000, 0, 0, 0, 0);
    step("reset1",  0, 0, OP_JUMP, 0, 0, 0, 16'h1234, 16'h0000, 0, 0, 0, 0);
    step("inc1",    1, 0, OP_INC,  0, 0, 0, 0,        16'h0001, 0, 0, 0, 0);
    step("inc2",    1, 0, OP_INC,  0, 0, 0, 0,        16'h0002, 0, 0, 0, 0);
    step("inc3",    1, 0, 3'b111,  0, 0, 0, 0,        16'h0003, 0, 0, 0, 0);
    step("jmp_ff",  1, 0, OP_JUMP, 0, 0, 0, 16'hFFFF, 16'hFFFF, 0, 0, 0, 0);
    step("inc_wrap",1, 0, OP_INC,  0, 0, 0, 0,        16'h0000, 0, 0, 0, 0);

    // branch conditions, flags ordered {V,C,N,Z}
    step("jmp10a",  1, 0, OP_JUMP,   0,      0,       0,     16'h0010, 16'h0010, 0, 0, 0, 0);
    step("br_lt_t", 1, 0, OP_BRANCH, CC_LT,  4'b0010, 8'hFC, 0,        16'h000C, 0, 0, 0, 0);
    step("jmp10b",  1, 0, OP_JUMP,   0,      0,       0,     16'h0010, 16'h0010, 0, 0, 0, 0);
    step("br_lt_f", 1, 0, OP_BRANCH, CC_LT,  4'b1010, 8'hFC, 0,        16'h0011, 0, 0, 0, 0);
    step("jmp10c",  1, 0, OP_JUMP,   0,      0,       0,     16'h0010, 16'h0010, 0, 0, 0, 0);
    step("br_gtz",  1, 0, OP_BRANCH, CC_GTZ, 4'b0000, 8'h05, 0,        16'h0015, 0, 0, 0, 0);
    step("br_le_z", 1, 0, OP_BRANCH, CC_LE,  4'b0001, 8'h02, 0,        16'h0017, 0, 0, 0, 0);
    step("br_cs_f", 1, 0, OP_BRANCH, CC_CS,  4'b0000, 8'h40, 0,        16'h0018, 0, 0, 0, 0);
    step("br_never",1, 0, OP_BRANCH, CC_NEVER,4'b1111,8'h40, 0,        16'h0019, 0, 0, 0, 0);
    step("jmp02",   1, 0, OP_JUMP,   0,      0,       0,     16'h0002, 16'h0002, 0, 0, 0, 0);
    step("br_wrapd",1, 0, OP_BRANCH, CC_ALWAYS,0,     8'h80, 0,        16'hFF82, 0, 0, 0, 0);
    step("br_wrapu",1, 0, OP_BRANCH, CC_VS,  4'b1000, 8'h7F, 0,        16'h0001, 0, 0, 0, 0);

    // nested call/return
    step("jmp20",   1, 0, OP_JUMP, 0, 0, 0, 16'h0020, 16'h0020, 0, 0, 0, 0);
    step("call1",   1, 0, OP_CALL, 0, 0, 0, 16'h0100, 16'h0100, 1, 0, 0, 0);
    step("call2",   1, 0, OP_CALL, 0, 0, 0, 16'h0200, 16'h0200, 2, 0, 0, 0);
    step("ret2",    1, 0, OP_RET,  0, 0, 0, 0,        16'h0101, 1, 0, 0, 0);
    step("ret1",    1, 0, OP_RET,  0, 0, 0, 0,        16'h0021, 0, 0, 0, 0);

    // overflow: nine calls, the first pushed address is lost
    step("jmp1000", 1, 0, OP_JUMP, 0, 0, 0, 16'h1000, 16'h1000, 0, 0, 0, 0);
    for (int k = 0; k < 9; k++)
      step($sformatf("ovf_call%0d", k), 1, 0, OP_CALL, 0, 0, 0,
           16'h1000 + 16'(16 * (k + 1)), 16'h1000 + 16'(16 * (k + 1)),
           4'((k < 8) ? k + 1 : 8), (k == 8), 0, 0);
    for (int j = 0; j < 8; j++)
      step($sformatf("ovf_ret%0d", j), 1, 0, OP_RET, 0, 0, 0, 0,
           16'h1000 + 16'(16 * (8 - j)) + 16'h0001, 4'(7 - j), 1, 0, 0);
    step("unf_ret", 1, 0, OP_RET, 0, 0, 0, 0, 16'h1012, 0, 1, 1, 0);

    // stall and halt
    step("stall_j", 1, 1, OP_JUMP, 0, 0, 0, 16'h0ABC, 16'h1012, 0, 1, 1, 0);
    step("stall_h", 1, 1, OP_HALT, 0, 0, 0, 0,        16'h1012, 0, 1, 1, 0);
    step("halt",    1, 0, OP_HALT, 0, 0, 0, 0,        16'h1012, 0, 1, 1, 1);
    step("halt_j",  1, 0, OP_JUMP, 0, 0, 0, 16'h0ABC, 16'h1012, 0, 1, 1, 1);
    step("halt_c",  1, 0, OP_CALL, 0, 0, 0, 16'h0ABC, 16'h1012, 0, 1, 1, 1);
    step("halt_rst",0, 0, OP_JUMP, 0, 0, 0, 16'h0ABC, 16'h0000, 0, 0, 0, 0);

    // reset coinciding with a call discards the push
    step("jmp300",  1, 0, OP_JUMP, 0, 0, 0, 16'h0300, 16'h0300, 0, 0, 0, 0);
    step("rst_call",0, 0, OP_CALL, 0, 0, 0, 16'h0400, 16'h0000, 0, 0, 0, 0);
    step("ret_empt",1, 0, OP_RET,  0, 0, 0, 0,        16'h0001, 0, 0, 1, 0);

    @(negedge clock);
    bus.op = OP_INC;
    repeat (4) @(posedge clock);
    #2;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: got %0d unchecked vectors, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised next-generation program-counter sequencer for the Simple Computer.
- Adds to the basic PC update (increment/jump/branch): configurable address width, a full condition-code branch set over V/C/N/Z, signed branch offsets, CALL/RET through an internal return-address stack (RAS), HALT and stall.
- Sits between the instruction decoder and instruction memory; PC output drives the fetch address.

Parameters:
PC_WIDTH, 16, width of PC, jump_addr and RAS entries
OFF_WIDTH, 8, width of signed branch_offset (sign-extended to PC_WIDTH)
RAS_DEPTH, 8, number of return-address stack entries (power of 2, >=2)
RESET_VECTOR, 0, PC value loaded at reset

Ports:
clock  in  1  CPU clock, all state updates on rising edge
reset  in  1  synchronous, active-low reset (0 = reset)
stall  in  1  1 = hold PC and RAS this cycle
op  in  3  sequencing operation (encoding below)
cond  in  4  branch condition code (BRANCH only)
V  in  1  overflow status
C  in  1  carry status
N  in  1  negative status
Z  in  1  zero status
branch_offset  in  OFF_WIDTH  signed two's-complement offset, relative to current PC
jump_addr  in  PC_WIDTH  absolute target for JUMP/CALL
PC  out  PC_WIDTH  current program counter
ras_count  out  clog2(RAS_DEPTH)+1  valid RAS entries
ras_overflow  out  1  sticky: CALL issued with RAS full
ras_underflow  out  1  sticky: RET issued with RAS empty
halted  out  1  1 while in HALT state

Behaviour:
- Reset (reset=0 at rising edge): PC=RESET_VECTOR, ras_count=0, ras_overflow=0, ras_underflow=0, halted=0, state=RUN. Reset dominates stall and op; reset mid-CALL discards the push.
- State machine: RUN and HALT. RUN -> HALT on op=HALT (not stalled). HALT -> RUN only via reset. In HALT, PC and RAS frozen; all ops ignored.
- Op encoding: 000 INC; 001 JUMP; 010 BRANCH; 011 CALL; 100 RET; 101 HALT; 110/111 treated as INC.
- Latency: one cycle. Op presented in cycle n yields new PC visible after edge n+1. All outputs registered.
- stall=1 in RUN: PC, RAS contents, ras_count, flags and state unchanged; op ignored.
- INC: PC <= PC+1.
- JUMP: PC <= jump_addr.
- BRANCH: if cond true, PC <= PC + sext(branch_offset); else PC <= PC+1.
- Condition codes:
  - 0 ALWAYS; 1 EQ Z; 2 NE ~Z
  - 3 LT N^V; 4 GE ~(N^V); 5 GT ~Z&~(N^V); 6 LE Z|(N^V)
  - 7 CS C; 8 CC ~C; 9 MI N; 10 PL ~N; 11 VS V; 12 VC ~V
  - 13 GTZ ~N&~Z (legacy branch-greater-than-zero); 14-15 NEVER
- CALL: push PC+1, PC <= jump_addr.
  - RAS full: oldest entry overwritten (circular), ras_count stays RAS_DEPTH, ras_overflow set. CALL still taken.
- RET: RAS non-empty: PC <= top entry, ras_count-1.
  - RAS empty: PC <= PC+1, ras_underflow set, count stays 0.
- Arithmetic modulo 2^PC_WIDTH: PC+1 at all-ones wraps to 0; branch target wraps both directions; carry-out discarded.
- Sticky flags clear only on reset.

Decomposition:
- Shared package pc_seq_pkg: op codes (OP_INC..OP_HALT), condition codes (CC_ALWAYS..CC_NEVER), state encoding (ST_RUN, ST_HALT).
- One sub-module: return_stack (circular LIFO, push/pop/full/empty/count, overwrite-oldest on full push). Condition evaluation and next-PC mux stay in pc_sequencer.

Test Plan:
- Reset and INC: hold reset=0 for 2 cycles, then INC x3 -> PC 0,1,2,3. PC=16'hFFFF then INC -> PC=0.
- BRANCH conditions at PC=16'h0010:
  - cond=LT, N=1, V=0, offset=8'hFC -> PC=16'h000C.
  - cond=LT, N=1, V=1 -> PC=16'h0011.
  - cond=GTZ, N=0, Z=0, offset=8'h05 -> PC=16'h0015.
- Nested CALL/RET: PC=16'h0020 CALL 16'h0100; at 16'h0100 CALL 16'h0200; RET; RET.
  - PC sequence: 0100, 0200, 0101, 0021.
  - ras_count 1,2,1,0.
- RAS overflow/underflow (RAS_DEPTH=8):
  - 9 CALLs -> ras_overflow=1, ras_count=8; 8 RETs return the 8 newest addresses.
  - 9th RET -> PC+1, ras_underflow=1.
- Stall and HALT:
  - stall=1 with op=JUMP 16'h0ABC -> PC unchanged.
  - HALT -> halted=1; subsequent JUMP ignored; reset=0 -> PC=RESET_VECTOR, halted=0.
- Reset during CALL: reset=0 in same cycle as CALL -> PC=RESET_VECTOR, ras_count=0, no flags set.
